alu16: RTL and testbench

//  16-bit datapath ALU: add, subtract, bitwise AND, bitwise NOT of B.

---
 rtl/alu16.sv | 96 +++++++++
 tb/tb_alu16.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu16.sv
// ---------------------------------------------------------------------------
// alu16
//   16-bit datapath ALU between the register-file read operands and the
//   writeback mux. The result and the Z/N/V flags are purely combinational.
//   A registered copy of the flags (status_q) is captured on request for the
//   controller's conditional-branch logic.
//
// Parameters
//   WIDTH     operand/result width in bits (>= 2); flags are always 3 bits
//
// Ports
//   clk       in   1      rising-edge clock, used only by the status register
//   reset_n   in   1      synchronous active-low reset of the status register
//   Ain       in   WIDTH  operand A
//   Bin       in   WIDTH  operand B
//   ALUop     in   2      00 A+B, 01 A-B, 10 A&B, 11 ~B
//   load_s    in   1      capture ZNO into status_q on this clock edge
//   out       out  WIDTH  combinational result
//   ZNO       out  3      combinational flags: [2]=Z, [1]=N, [0]=V
//   status_q  out  3      registered flags, same bit order as ZNO
// ---------------------------------------------------------------------------
module alu16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [1:0]       ALUop,
  input  logic             load_s,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       ZNO,
  output logic [2:0]       status_q
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             a_msb;
  logic             b_msb;
  logic             r_msb;
  logic [2:0]       status_d;

  assign a_msb = Ain[WIDTH-1];
  assign b_msb = Bin[WIDTH-1];
  assign r_msb = result[WIDTH-1];

  // Result and signed overflow. Subtraction is A + ~B + 1, so it overflows
  // when the operand signs differ and the result sign departs from A.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (ALUop)
      OP_ADD: begin
        result = Ain + Bin;
        ovf    = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OP_SUB: begin
        result = Ain + ~Bin + WIDTH'(1);
        ovf    = (a_msb != b_msb) && (r_msb != a_msb);
      end
      OP_AND: begin
        result = Ain & Bin;
      end
      OP_NOT: begin
        result = ~Bin;
      end
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

  assign out = result;
  assign ZNO = {(result == '0), r_msb, ovf};

  // Reset takes priority over a load request; otherwise hold.
  always_comb begin
    status_d = status_q;
    if (!reset_n) begin
      status_d = 3'b000;
    end else if (load_s) begin
      status_d = ZNO;
    end
  end

  always_ff @(posedge clk) begin
    status_q <= status_d;
  end

endmodule

// File: tb/tb_alu16.sv
// ---------------------------------------------------------------------------
// tb_alu16
//   Self-checking bench for alu16. Expected result/flag pairs are pushed to a
//   scoreboard queue when operands are driven and popped when the
//   combinational outputs are sampled. The status register is checked
//   against a bench-side expected value.
// ---------------------------------------------------------------------------
module tb_alu16;

  logic        clk;
  logic        reset_n;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic [1:0]  ALUop;
  logic        load_s;
  logic [15:0] out;
  logic [2:0]  ZNO;
  logic [2:0]  status_q;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  zno;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_item;
  int   n_checks;
  int   n_fail;

  alu16 #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Ain      (Ain),
    .Bin      (Bin),
    .ALUop    (ALUop),
    .load_s   (load_s),
    .out      (out),
    .ZNO      (ZNO),
    .status_q (status_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model working in signed integer arithmetic: overflow is
  // detected by the true result leaving the 16-bit signed range.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] op);
    int   sa;
    int   sb;
    int   r;
    logic v;
    exp_t e;
    sa = int'(signed'(a));
    sb = int'(signed'(b));
    v  = 1'b0;
    case (op)
      2'b00: begin r = sa + sb; v = (r > 32767) || (r < -32768); end
      2'b01: begin r = sa - sb; v = (r > 32767) || (r < -32768); end
      2'b10: r = int'(a & b);
      default: r = int'(~b);
    endcase
    e.res = 16'(r);
    e.zno = {(e.res == 16'h0000), e.res[15], v};
    return e;
  endfunction

  // Drives one operation and pushes its expected outputs to the scoreboard.
  task automatic drive_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input logic [15:0] e_res,
                          input logic [2:0] e_zno);
    exp_t e;
    Ain   = a;
    Bin   = b;
    ALUop = op;
    e.res = e_res;
    e.zno = e_zno;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    load_s  = 1'b1;
    drive_op(16'h7FFF, 16'h0001, 2'b00, 16'h8000, 3'b011);
    #1;
    exp_item = sb_q.pop_front();
    n_checks++;
    if (out !== exp_item.res || ZNO !== exp_item.zno) begin
      n_fail++;
      $display("[TB] FAIL reset_comb: out=%h ZNO=%b expected out=%h ZNO=%b",
               out, ZNO, exp_item.res, exp_item.zno);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (status_q !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_status: status_q=%b expected 000", status_q);
    end
  endtask

  task automatic test_arith();
    logic [15:0] a_v [8];
    logic [15:0] b_v [8];
    logic [1:0]  o_v [8];
    logic [15:0] r_v [8];
    logic [2:0]  z_v [8];
    a_v = '{16'h0000, 16'h0003, 16'h0003, 16'h7FFE, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
    b_v = '{16'h0001, 16'h0001, 16'h0007, 16'h000F, 16'h0001, 16'h0001, 16'h0001, 16'h0000};
    o_v = '{2'b00,    2'b01,    2'b01,    2'b00,    2'b01,    2'b00,    2'b00,    2'b01};
    r_v = '{16'h0001, 16'h0002, 16'hFFFC, 16'h800D, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
    z_v = '{3'b000,   3'b000,   3'b010,   3'b011,   3'b001,   3'b011,   3'b100,   3'b100};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_op(a_v[i], b_v[i], o_v[i], r_v[i], z_v[i]);
      #1;
      exp_item = sb_q.pop_front();
      n_checks++;
      if (out !== exp_item.res || ZNO !== exp_item.zno) begin
        n_fail++;
        $display("[TB] FAIL arith[%0d]: out=%h ZNO=%b expected out=%h ZNO=%b",
                 i, out, ZNO, exp_item.res, exp_item.zno);
      end
    end
  endtask

  task automatic test_logic();
    logic [15:0] a_v [4];
    logic [15:0] b_v [4];
    logic [1:0]  o_v [4];
    logic [15:0] r_v [4];
    logic [2:0]  z_v [4];
    a_v = '{16'h4403, 16'h4403, 16'hF0F0, 16'h1234};
    b_v = '{16'h0000, 16'hFFFE, 16'h8FF0, 16'h0000};
    o_v = '{2'b10,    2'b11,    2'b10,    2'b11};
    r_v = '{16'h0000, 16'h0001, 16'h80F0, 16'hFFFF};
    z_v = '{3'b100,   3'b000,   3'b010,   3'b010};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_op(a_v[i], b_v[i], o_v[i], r_v[i], z_v[i]);
      #1;
      exp_item = sb_q.pop_front();
      n_checks++;
      if (out !== exp_item.res || ZNO !== exp_item.zno) begin
        n_fail++;
        $display("[TB] FAIL logic[%0d]: out=%h ZNO=%b expected out=%h ZNO=%b",
                 i, out, ZNO, exp_item.res, exp_item.zno);
      end
    end
  endtask

  task automatic test_status();
    // Load the overflow-add flags.
    @(negedge clk);
    reset_n = 1'b1;
    load_s  = 1'b1;
    drive_op(16'h7FFE, 16'h000F, 2'b00, 16'h800D, 3'b011);
    @(posedge clk);
    #1;
    exp_item = sb_q.pop_front();
    n_checks++;
    if (status_q !== 3'b011) begin
      n_fail++;
      $display("[TB] FAIL status_load: status_q=%b expected 011", status_q);
    end
    // New inputs without load must leave the register untouched.
    @(negedge clk);
    load_s = 1'b0;
    drive_op(16'h0000, 16'h0000, 2'b01, 16'h0000, 3'b100);
    #1;
    exp_item = sb_q.pop_front();
    n_checks++;
    if (ZNO !== exp_item.zno) begin
      n_fail++;
      $display("[TB] FAIL status_hold_comb: ZNO=%b expected %b", ZNO, exp_item.zno);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (status_q !== 3'b011) begin
      n_fail++;
      $display("[TB] FAIL status_hold: status_q=%b expected 011", status_q);
    end
    // Load the zero flag.
    @(negedge clk);
    load_s = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (status_q !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL status_reload: status_q=%b expected 100", status_q);
    end
    // Reset wins over load and clears a nonzero status.
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (status_q !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL status_reset_wins: status_q=%b expected 000", status_q);
    end
    @(negedge clk);
    reset_n = 1'b1;
    load_s  = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    exp_t        e;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 2'($urandom_range(0, 3));
      if (i % 8 == 0) a = {a[15], 15'h7FFF};
      e = model(a, b, op);
      drive_op(a, b, op, e.res, e.zno);
      #1;
      exp_item = sb_q.pop_front();
      n_checks++;
      if (out !== exp_item.res || ZNO !== exp_item.zno) begin
        n_fail++;
        $display("[TB] FAIL random[%0d] A=%h B=%h op=%b: out=%h ZNO=%b expected out=%h ZNO=%b",
                 i, a, b, op, out, ZNO, exp_item.res, exp_item.zno);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    load_s   = 1'b0;
    Ain      = '0;
    Bin      = '0;
    ALUop    = 2'b00;
    test_reset();
    test_arith();
    test_logic();
    test_status();
    test_random();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
